// File: rtl/reg_interface_pkg.sv
// Shared types and constants for the host register interface.
//   - register numbers for the host-visible map
//   - STATUS bit positions
//   - request FSM state encoding
//   - byte/word types and a big-endian byte picker
package reg_interface_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;

  localparam logic [3:0] XR_WR_ADDR  = 4'd0;
  localparam logic [3:0] XR_WR_INCR  = 4'd1;
  localparam logic [3:0] XR_RD_ADDR  = 4'd2;
  localparam logic [3:0] XR_RD_INCR  = 4'd3;
  localparam logic [3:0] XR_DATA     = 4'd4;
  localparam logic [3:0] XR_STATUS   = 4'd5;
  localparam logic [3:0] XR_SCRATCH0 = 4'd6;

  localparam int NUM_SCRATCH = 10;

  localparam int ST_BUSY    = 15;
  localparam int ST_OVERRUN = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2
  } reg_state_t;

  // Even byte is the MSB.
  function automatic byte_t pick_byte(input word_t w, input logic odd);
    return odd ? w[7:0] : w[15:8];
  endfunction

endpackage

// File: rtl/reg_interface.sv
// Host register interface: assembles byte writes into 16-bit registers,
// drives the registered read-back byte and runs VRAM request/ack
// handshakes for data-port writes and prefetching reads.
// Ports:
//   clk, reset_n_i              clock, async active-low reset
//   write_strobe_i/read_strobe_i single-cycle host strobes
//   reg_num_i, bytesel_i         register number, 0 = even (MSB), 1 = odd
//   bytedata_i                   written byte
//   rd_byte_o                    registered read-back byte
//   vram_sel_o/wr_o/addr_o/data_o VRAM request, held until vram_ack_i
//   vram_ack_i, vram_data_i      completion pulse and read data
module reg_interface
  import reg_interface_pkg::*;
#(
  parameter int          VRAM_AW    = 16,
  parameter logic [15:0] RESET_INCR = 16'h0001
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               write_strobe_i,
  input  logic               read_strobe_i,
  input  logic [3:0]         reg_num_i,
  input  logic               bytesel_i,
  input  logic [7:0]         bytedata_i,
  output logic [7:0]         rd_byte_o,
  output logic               vram_sel_o,
  output logic               vram_wr_o,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output logic [15:0]        vram_data_o,
  input  logic               vram_ack_i,
  input  logic [15:0]        vram_data_i
);

  // Address arithmetic wraps at 2^VRAM_AW.
  localparam word_t AMASK = word_t'((32'h1 << VRAM_AW) - 1);

  reg_state_t state_q, state_d;
  byte_t      hold_q, hold_d;
  word_t      wr_addr_q, wr_addr_d, wr_incr_q, wr_incr_d;
  word_t      rd_addr_q, rd_addr_d, rd_incr_q, rd_incr_d;
  word_t      scratch_q [NUM_SCRATCH];
  word_t      scratch_d [NUM_SCRATCH];
  logic       overrun_q, overrun_d;
  // Pending slots hold requests not yet handed to the VRAM port; the
  // in-flight request lives in the vram_* output registers.
  logic       wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  word_t      wr_pend_addr_q, wr_pend_addr_d, wr_pend_data_q, wr_pend_data_d;
  word_t      rd_pend_addr_q, rd_pend_addr_d;
  word_t      rd_buf_q, rd_buf_d;
  logic       sel_q, sel_d, wr_q, wr_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  word_t      data_q, data_d;
  byte_t      rd_byte_q, rd_byte_d;

  logic       wcommit, rdata, busy;
  word_t      word_w, rd_next, rv;
  logic [3:0] sidx;

  assign word_w  = {hold_q, bytedata_i};
  assign wcommit = write_strobe_i & bytesel_i;
  // A write strobe in the same cycle takes priority over a read.
  assign rdata   = read_strobe_i & ~write_strobe_i & bytesel_i & (reg_num_i == XR_DATA);
  assign rd_next = (rd_addr_q + rd_incr_q) & AMASK;
  assign sidx    = reg_num_i - XR_SCRATCH0;
  assign busy    = wr_pend_q | rd_pend_q | (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    wr_addr_d      = wr_addr_q;
    wr_incr_d      = wr_incr_q;
    rd_addr_d      = rd_addr_q;
    rd_incr_d      = rd_incr_q;
    scratch_d      = scratch_q;
    overrun_d      = overrun_q;
    wr_pend_d      = wr_pend_q;
    wr_pend_addr_d = wr_pend_addr_q;
    wr_pend_data_d = wr_pend_data_q;
    rd_pend_d      = rd_pend_q;
    rd_pend_addr_d = rd_pend_addr_q;
    rd_buf_d       = rd_buf_q;
    sel_d          = sel_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    data_d         = data_q;

    if (write_strobe_i && !bytesel_i) hold_d = bytedata_i;

    if (wcommit) begin
      case (reg_num_i)
        XR_WR_ADDR: wr_addr_d = word_w;
        XR_WR_INCR: wr_incr_d = word_w;
        XR_RD_ADDR: begin
          rd_addr_d      = word_w;
          rd_pend_d      = 1'b1;
          rd_pend_addr_d = word_w;
        end
        XR_RD_INCR: rd_incr_d = word_w;
        XR_DATA: begin
          // Replacing a write that never reached the port loses it.
          if (wr_pend_q) overrun_d = 1'b1;
          wr_pend_d      = 1'b1;
          wr_pend_addr_d = wr_addr_q;
          wr_pend_data_d = word_w;
          wr_addr_d      = (wr_addr_q + wr_incr_q) & AMASK;
        end
        XR_STATUS: overrun_d = 1'b0;
        default:   scratch_d[sidx] = word_w;
      endcase
    end

    if (rdata) begin
      rd_addr_d      = rd_next;
      rd_pend_d      = 1'b1;
      rd_pend_addr_d = rd_next;
    end

    // IDLE looks at the post-load pending state so a commit this cycle
    // raises sel on the very next edge.
    case (state_q)
      IDLE: begin
        if (wr_pend_d) begin
          state_d   = WR_REQ;
          sel_d     = 1'b1;
          wr_d      = 1'b1;
          addr_d    = wr_pend_addr_d[VRAM_AW-1:0];
          data_d    = wr_pend_data_d;
          wr_pend_d = 1'b0;
        end else if (rd_pend_d) begin
          state_d   = RD_REQ;
          sel_d     = 1'b1;
          wr_d      = 1'b0;
          addr_d    = rd_pend_addr_d[VRAM_AW-1:0];
          rd_pend_d = 1'b0;
        end
      end
      WR_REQ, RD_REQ: begin
        if (vram_ack_i) begin
          state_d = IDLE;
          sel_d   = 1'b0;
          if (state_q == RD_REQ) rd_buf_d = vram_data_i;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 1'b0;
      end
    endcase
  end

  // Read-back mux, registered every cycle.
  always_comb begin
    rv = '0;
    case (reg_num_i)
      XR_WR_ADDR: rv = wr_addr_q;
      XR_WR_INCR: rv = wr_incr_q;
      XR_RD_ADDR: rv = rd_addr_q;
      XR_RD_INCR: rv = rd_incr_q;
      XR_DATA:    rv = rd_buf_q;
      XR_STATUS:  rv = {busy, overrun_q, 14'b0};
      default:    rv = scratch_q[sidx];
    endcase
    rd_byte_d = pick_byte(rv, bytesel_i);
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      wr_addr_q      <= '0;
      wr_incr_q      <= RESET_INCR;
      rd_addr_q      <= '0;
      rd_incr_q      <= RESET_INCR;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
      overrun_q      <= 1'b0;
      wr_pend_q      <= 1'b0;
      wr_pend_addr_q <= '0;
      wr_pend_data_q <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_addr_q <= '0;
      rd_buf_q       <= '0;
      sel_q          <= 1'b0;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      rd_byte_q      <= '0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      wr_addr_q      <= wr_addr_d;
      wr_incr_q      <= wr_incr_d;
      rd_addr_q      <= rd_addr_d;
      rd_incr_q      <= rd_incr_d;
      scratch_q      <= scratch_d;
      overrun_q      <= overrun_d;
      wr_pend_q      <= wr_pend_d;
      wr_pend_addr_q <= wr_pend_addr_d;
      wr_pend_data_q <= wr_pend_data_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_addr_q <= rd_pend_addr_d;
      rd_buf_q       <= rd_buf_d;
      sel_q          <= sel_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      rd_byte_q      <= rd_byte_d;
    end
  end

  assign rd_byte_o   = rd_byte_q;
  assign vram_sel_o  = sel_q;
  assign vram_wr_o   = wr_q;
  assign vram_addr_o = addr_q;
  assign vram_data_o = data_q;

endmodule

// File: tb/tb_reg_interface.sv
// Directed bench for reg_interface: byte assembly, read-back, VRAM
// write/read handshakes, overrun, priority and async reset.
module tb_reg_interface;

  logic        gclk = 1'b0;
  logic        rst_n;
  logic        wr_stb, rd_stb, bsel, ack;
  logic [3:0]  rnum;
  logic [7:0]  bdata, rd_byte;
  logic        sel, vwr;
  logic [15:0] vaddr, vdata_o, vdata_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 gclk = ~gclk;

  reg_interface #(.VRAM_AW(16), .RESET_INCR(16'h0001)) dut (
    .clk            (gclk),
    .reset_n_i      (rst_n),
    .write_strobe_i (wr_stb),
    .read_strobe_i  (rd_stb),
    .reg_num_i      (rnum),
    .bytesel_i      (bsel),
    .bytedata_i     (bdata),
    .rd_byte_o      (rd_byte),
    .vram_sel_o     (sel),
    .vram_wr_o      (vwr),
    .vram_addr_o    (vaddr),
    .vram_data_o    (vdata_o),
    .vram_ack_i     (ack),
    .vram_data_i    (vdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_byte(input logic [3:0] r, input logic odd, input logic [7:0] d);
    @(negedge gclk);
    wr_stb = 1'b1; rnum = r; bsel = odd; bdata = d;
    @(negedge gclk);
    wr_stb = 1'b0;
  endtask

  task automatic wr_word(input logic [3:0] r, input logic [15:0] w);
    wr_byte(r, 1'b0, w[15:8]);
    wr_byte(r, 1'b1, w[7:0]);
  endtask

  task automatic rd_reg(input logic [3:0] r, input logic odd, output logic [7:0] b);
    @(negedge gclk);
    rnum = r; bsel = odd;
    @(negedge gclk);
    b = rd_byte;
  endtask

  task automatic rd_strobe(input logic [3:0] r, input logic odd);
    @(negedge gclk);
    rd_stb = 1'b1; rnum = r; bsel = odd;
    @(negedge gclk);
    rd_stb = 1'b0;
  endtask

  task automatic do_ack(input logic [15:0] d);
    @(negedge gclk);
    ack = 1'b1; vdata_i = d;
    @(negedge gclk);
    ack = 1'b0; vdata_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge gclk);
  endtask

  logic [7:0] b;

  initial begin
    rst_n = 1'b0; wr_stb = 0; rd_stb = 0; bsel = 0; ack = 0;
    rnum = '0; bdata = '0; vdata_i = '0;
    idle(3);
    chk("rst_sel",   {31'b0, sel}, 0);
    chk("rst_rdb",   {24'b0, rd_byte}, 0);
    chk("rst_addr",  {16'b0, vaddr}, 0);
    rst_n = 1'b1;

    rd_reg(4'd1, 1'b0, b); chk("incr_msb", {24'b0, b}, 32'h00);
    rd_reg(4'd1, 1'b1, b); chk("incr_lsb", {24'b0, b}, 32'h01);
    chk("idle_sel", {31'b0, sel}, 0);

    // Scratch at the top of the map
    wr_word(4'd15, 16'hBEEF);
    rd_reg(4'd15, 1'b0, b); chk("scr_msb", {24'b0, b}, 32'hBE);
    rd_reg(4'd15, 1'b1, b); chk("scr_lsb", {24'b0, b}, 32'hEF);

    // Data-port write
    wr_word(4'd0, 16'h1234);
    wr_word(4'd4, 16'hABCD);
    chk("w1_sel",  {31'b0, sel}, 1);
    chk("w1_wr",   {31'b0, vwr}, 1);
    chk("w1_addr", {16'b0, vaddr}, 32'h1234);
    chk("w1_data", {16'b0, vdata_o}, 32'hABCD);
    idle(3);
    chk("w1_hold", {15'b0, sel, vaddr}, 32'h1_1234);
    rd_reg(4'd5, 1'b0, b); chk("w1_busy", {24'b0, b}, 32'h80);
    do_ack(16'h0);
    chk("w1_done", {31'b0, sel}, 0);
    rd_reg(4'd0, 1'b0, b); chk("wa_msb", {24'b0, b}, 32'h12);
    rd_reg(4'd0, 1'b1, b); chk("wa_lsb", {24'b0, b}, 32'h35);

    // Read with prefetch and wrap
    wr_word(4'd3, 16'h0002);
    wr_word(4'd2, 16'hFFFF);
    chk("r1_sel",  {31'b0, sel}, 1);
    chk("r1_wr",   {31'b0, vwr}, 0);
    chk("r1_addr", {16'b0, vaddr}, 32'hFFFF);
    do_ack(16'h5A5A);
    rd_reg(4'd4, 1'b0, b); chk("rb_msb", {24'b0, b}, 32'h5A);
    rd_reg(4'd4, 1'b1, b); chk("rb_lsb", {24'b0, b}, 32'h5A);
    rd_strobe(4'd4, 1'b1);
    chk("r2_sel",  {31'b0, sel}, 1);
    chk("r2_addr", {16'b0, vaddr}, 32'h0001);
    rd_reg(4'd2, 1'b1, b); chk("ra_wrap", {24'b0, b}, 32'h01);
    do_ack(16'h0000);

    // Back-to-back writes while the first is stalled
    wr_word(4'd4, 16'h1111);
    chk("b1_data", {16'b0, vdata_o}, 32'h1111);
    chk("b1_addr", {16'b0, vaddr}, 32'h1235);
    wr_word(4'd4, 16'h2222);
    idle(4);
    chk("b1_stall", {15'b0, sel, vdata_o}, 32'h1_1111);
    rd_reg(4'd5, 1'b0, b); chk("b_noovr", {24'b0, b}, 32'h80);
    do_ack(16'h0);
    chk("b_gap", {31'b0, sel}, 0);
    idle(1);
    chk("b2_data", {15'b0, sel, vdata_o}, 32'h1_2222);
    chk("b2_addr", {16'b0, vaddr}, 32'h1236);
    do_ack(16'h0);
    idle(3);
    chk("b_no3rd", {31'b0, sel}, 0);

    // Overrun: replace a queued write that never reached the port
    wr_word(4'd4, 16'h4444);
    wr_word(4'd4, 16'h5555);
    wr_word(4'd4, 16'h6666);
    rd_reg(4'd5, 1'b0, b); chk("ovr_msb", {24'b0, b}, 32'hC0);
    rd_reg(4'd5, 1'b1, b); chk("ovr_lsb", {24'b0, b}, 32'h00);
    wr_word(4'd5, 16'h0000);
    rd_reg(4'd5, 1'b0, b); chk("ovr_clr", {24'b0, b}, 32'h80);
    do_ack(16'h0);
    idle(1);
    chk("ovr_data", {16'b0, vdata_o}, 32'h6666);
    chk("ovr_addr", {16'b0, vaddr}, 32'h1239);
    do_ack(16'h0);
    rd_reg(4'd5, 1'b0, b); chk("st_idle", {24'b0, b}, 32'h00);

    // Write and read queued together: write goes first
    wr_word(4'd4, 16'h7777);
    wr_word(4'd2, 16'h0040);
    wr_word(4'd4, 16'h8888);
    do_ack(16'h0);
    idle(1);
    chk("pri_wr",   {15'b0, vwr, vdata_o}, 32'h1_8888);
    chk("pri_wadr", {16'b0, vaddr}, 32'h123B);
    do_ack(16'h0);
    idle(1);
    chk("pri_rd",   {30'b0, sel, vwr}, 32'b10);
    chk("pri_radr", {16'b0, vaddr}, 32'h0040);

    // Async reset mid-RD_REQ
    @(negedge gclk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sel",  {31'b0, sel}, 0);
    chk("ar_addr", {16'b0, vaddr}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("ar_nosel", {31'b0, sel}, 0);
    rd_reg(4'd0, 1'b1, b);  chk("ar_wa",   {24'b0, b}, 32'h00);
    rd_reg(4'd3, 1'b1, b);  chk("ar_ri",   {24'b0, b}, 32'h01);
    rd_reg(4'd4, 1'b1, b);  chk("ar_buf",  {24'b0, b}, 32'h00);
    rd_reg(4'd15, 1'b0, b); chk("ar_scr",  {24'b0, b}, 32'h00);
    rd_reg(4'd5, 1'b0, b);  chk("ar_st",   {24'b0, b}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
